// File: rtl/dac_frame_scheduler_if.sv
// Requester handshakes and DAC serial pins of the DAC frame scheduler.
interface dac_frame_scheduler_if #(
   parameter int DATA_W = 16
);
   logic              req0;
   logic [DATA_W-1:0] data0;
   logic              ack0;
   logic              req1;
   logic [DATA_W-1:0] data1;
   logic              ack1;
   logic              clk_out;
   logic              sync_out;
   logic              din;
   logic              busy;
   logic              led;

   modport slave (
      input  req0, data0, req1, data1,
      output ack0, ack1, clk_out, sync_out, din, busy, led
   );

   modport master (
      output req0, data0, req1, data1,
      input  ack0, ack1, clk_out, sync_out, din, busy, led
   );
endinterface

// File: rtl/dac_frame_scheduler.sv
// Round-robin arbiter for two requesters sharing one sync-framed, MSB-first serial DAC link.
//
// state   | meaning
// S_IDLE  | link idle, arbitrate and grant on any pending request
// S_SHIFT | sync low, shifting DATA_W bits, CLK_DIV cycles per clk_out phase
// S_GAP   | sync high for GAP cycles before arbitration resumes
module dac_frame_scheduler #(
   parameter int DATA_W  = 16,
   parameter int CLK_DIV = 4,
   parameter int GAP     = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   dac_frame_scheduler_if.slave  bus
);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

   state_t            state_q;
   logic [DATA_W-1:0] shreg_q;
   logic [DIV_W-1:0]  div_q;
   logic [BIT_W-1:0]  bit_q;
   logic [GAP_W-1:0]  gap_q;
   logic              last_q;
   logic              ack0_q;
   logic              ack1_q;
   logic              clk_out_q;
   logic              sync_q;
   logic              din_q;
   logic              busy_q;
   logic              led_q;

   logic              gnt1_d;
   logic [DATA_W-1:0] word_d;

   // On a tie the requester that did not win last time is granted.
   always_comb begin
      gnt1_d = bus.req1 & (~bus.req0 | ~last_q);
      word_d = gnt1_d ? bus.data1 : bus.data0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         shreg_q   <= '0;
         div_q     <= '0;
         bit_q     <= '0;
         gap_q     <= '0;
         last_q    <= 1'b1;
         ack0_q    <= 1'b0;
         ack1_q    <= 1'b0;
         clk_out_q <= 1'b1;
         sync_q    <= 1'b1;
         din_q     <= 1'b0;
         busy_q    <= 1'b0;
         led_q     <= 1'b0;
      end else begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.req0 || bus.req1) begin
                  shreg_q   <= word_d;
                  din_q     <= word_d[DATA_W-1];
                  ack0_q    <= ~gnt1_d;
                  ack1_q    <= gnt1_d;
                  last_q    <= gnt1_d;
                  sync_q    <= 1'b0;
                  clk_out_q <= 1'b1;
                  div_q     <= DIV_LAST;
                  bit_q     <= BIT_LAST;
                  busy_q    <= 1'b1;
                  state_q   <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (div_q != '0) begin
                  div_q <= div_q - 1'b1;
               end else begin
                  div_q <= DIV_LAST;
                  if (clk_out_q) begin
                     clk_out_q <= 1'b0;
                  end else if (bit_q == '0) begin
                     clk_out_q <= 1'b1;
                     sync_q    <= 1'b1;
                     din_q     <= 1'b0;
                     led_q     <= ~led_q;
                     gap_q     <= GAP_LAST;
                     state_q   <= S_GAP;
                  end else begin
                     // Next bit is presented on the rising edge of clk_out.
                     bit_q     <= bit_q - 1'b1;
                     shreg_q   <= {shreg_q[DATA_W-2:0], 1'b0};
                     din_q     <= shreg_q[DATA_W-2];
                     clk_out_q <= 1'b1;
                  end
               end
            end
            S_GAP: begin
               if (gap_q == '0) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  gap_q <= gap_q - 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.ack0     = ack0_q;
   assign bus.ack1     = ack1_q;
   assign bus.clk_out  = clk_out_q;
   assign bus.sync_out = sync_q;
   assign bus.din      = din_q;
   assign bus.busy     = busy_q;
   assign bus.led      = led_q;
endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Self-checking bench for dac_frame_scheduler: frame-timing model plus directed scenarios.
module tb_dac_frame_scheduler;
   localparam int DW = 16;
   localparam int CD = 2;
   localparam int GP = 2;
   localparam int T  = 2 * CD * DW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;

   dac_frame_scheduler_if #(.DATA_W(DW)) bus ();

   dac_frame_scheduler #(.DATA_W(DW), .CLK_DIV(CD), .GAP(GP)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Model: a frame is described only by its start edge and the word; outputs follow from elapsed time.
   bit          m_active = 1'b0;
   int          m_t = 0;
   bit          m_last = 1'b1;
   bit          m_led = 1'b0;
   bit          m_ack0 = 1'b0;
   bit          m_ack1 = 1'b0;
   logic [15:0] m_word = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 1'b0; m_t = 0; m_last = 1'b1; m_led = 1'b0;
         m_ack0 = 1'b0; m_ack1 = 1'b0; m_word = '0;
      end else begin
         m_ack0 = 1'b0;
         m_ack1 = 1'b0;
         if (m_active && m_t < T + GP) begin
            m_t++;
            if (m_t == T) m_led = !m_led;
         end else begin
            m_active = 1'b0;
            if (bus.req0 || bus.req1) begin
               bit pick;
               pick     = (bus.req0 && bus.req1) ? !m_last : bus.req1;
               m_word   = pick ? bus.data1 : bus.data0;
               m_last   = pick;
               m_ack0   = !pick;
               m_ack1   = pick;
               m_active = 1'b1;
               m_t      = 0;
            end
         end
      end
   end

   // Monitor: what a DAC would see, plus handshake history.
   int          ack_who[$];
   int          ack_cyc[$];
   logic [15:0] frames[$];
   int          falls_q[$];
   int          lens[$];
   int          gaps[$];
   bit          in_frame = 1'b0, seen_rise = 1'b0, prev_clk = 1'b1, prev_sync = 1'b1;
   logic [15:0] cap = '0;
   int          mon_falls = 0, slen = 0, hi_cnt = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         in_frame = 1'b0; seen_rise = 1'b0; prev_clk = 1'b1; prev_sync = 1'b1;
         mon_falls = 0; slen = 0; hi_cnt = 0;
      end else begin
         if (bus.ack0) begin ack_who.push_back(0); ack_cyc.push_back(cyc); end
         if (bus.ack1) begin ack_who.push_back(1); ack_cyc.push_back(cyc); end
         if (prev_sync && !bus.sync_out) begin
            in_frame = 1'b1; cap = '0; mon_falls = 0; slen = 0;
            if (seen_rise) gaps.push_back(hi_cnt);
         end
         if (in_frame && !bus.sync_out) slen++;
         if (in_frame && !bus.sync_out && prev_clk && !bus.clk_out) begin
            cap = {cap[14:0], bus.din};
            mon_falls++;
         end
         if (in_frame && !prev_sync && bus.sync_out) begin
            frames.push_back(cap); falls_q.push_back(mon_falls); lens.push_back(slen);
            in_frame = 1'b0; seen_rise = 1'b1; hi_cnt = 0;
         end
         if (bus.sync_out) hi_cnt++;
         prev_sync = bus.sync_out;
         prev_clk  = bus.clk_out;
      end
   end

   // Literal expectations posted by the stimulus, evaluated by the single compare process.
   string       lit_name[$];
   logic [31:0] lit_act[$];
   logic [31:0] lit_exp[$];
   int          lit_rd = 0;
   int          errors = 0;
   int          checks = 0;

   always @(negedge clk) begin
      logic [6:0] act, exp;
      while (lit_rd < lit_act.size()) begin
         checks++;
         if (lit_act[lit_rd] !== lit_exp[lit_rd]) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", lit_name[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
         end
         lit_rd++;
      end
      if (rst_n) begin
         act = {bus.ack0, bus.ack1, bus.clk_out, bus.sync_out, bus.din, bus.busy, bus.led};
         if (m_active && m_t < T)
            exp = {m_ack0, m_ack1, ((m_t % (2 * CD)) < CD), 1'b0, m_word[DW-1-(m_t/(2*CD))], 1'b1, m_led};
         else
            exp = {m_ack0, m_ack1, 1'b1, 1'b1, 1'b0, (m_active && m_t < T + GP), m_led};
         checks++;
         if (act !== exp) begin
            errors++;
            $display("FAIL model_cmp cyc=%0d {ack0,ack1,clk_out,sync,din,busy,led} got %b expected %b", cyc, act, exp);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
      lit_name.push_back(nm);
      lit_act.push_back(act);
      lit_exp.push_back(exp);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      repeat (3) tick();
      lit("reset_sync", {31'd0, bus.sync_out}, 1);
      lit("reset_clk_out", {31'd0, bus.clk_out}, 1);
      lit("reset_led", {31'd0, bus.led}, 0);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_acks(input int n, input int budget, input string nm);
      int k = 0;
      while (ack_who.size() < n && k < budget) begin tick(); k++; end
      if (ack_who.size() < n) lit(nm, ack_who.size(), n);
   endtask

   task automatic wait_frames(input int n, input int budget, input string nm);
      int k = 0;
      while (frames.size() < n && k < budget) begin tick(); k++; end
      if (frames.size() < n) lit(nm, frames.size(), n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ab, fb, gb, c0, k;
      bus.req0 = 1'b0; bus.req1 = 1'b0; bus.data0 = '0; bus.data1 = '0;

      // 1: single frame
      do_reset();
      ab = ack_who.size(); fb = frames.size();
      bus.data0 = 16'hA5C3; bus.req0 = 1'b1; c0 = cyc;
      wait_acks(ab + 1, 10, "t1_ack_timeout");
      bus.req0 = 1'b0;
      lit("t1_ack_latency", ack_cyc[ab] - c0, 1);
      lit("t1_ack_who", ack_who[ab], 0);
      wait_frames(fb + 1, 200, "t1_frame_timeout");
      lit("t1_word", frames[fb], 16'hA5C3);
      lit("t1_falls", falls_q[fb], 16);
      lit("t1_sync_low", lens[fb], 64);
      lit("t1_led", {31'd0, bus.led}, 1);

      // 2: tie, round robin
      do_reset();
      ab = ack_who.size(); fb = frames.size(); gb = gaps.size();
      bus.data0 = 16'h1234; bus.data1 = 16'hBEEF; bus.req0 = 1'b1; bus.req1 = 1'b1;
      wait_acks(ab + 3, 300, "t2_ack_timeout");
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      wait_frames(fb + 3, 200, "t2_frame_timeout");
      lit("t2_who0", ack_who[ab], 0);
      lit("t2_who1", ack_who[ab + 1], 1);
      lit("t2_who2", ack_who[ab + 2], 0);
      lit("t2_word0", frames[fb], 16'h1234);
      lit("t2_word1", frames[fb + 1], 16'hBEEF);
      lit("t2_word2", frames[fb + 2], 16'h1234);
      lit("t2_gap", gaps[gb], 3);

      // 3: held request, back-to-back frames
      do_reset();
      ab = ack_who.size(); fb = frames.size(); gb = gaps.size();
      bus.data1 = 16'h00FF; bus.req1 = 1'b1;
      wait_acks(ab + 3, 300, "t3_ack_timeout");
      bus.req1 = 1'b0;
      wait_frames(fb + 3, 200, "t3_frame_timeout");
      repeat (10) tick();
      lit("t3_ack_count", ack_who.size() - ab, 3);
      lit("t3_who", ack_who[ab] + ack_who[ab + 1] + ack_who[ab + 2], 3);
      lit("t3_spacing", ack_cyc[ab + 1] - ack_cyc[ab], T + GP + 1);
      lit("t3_word0", frames[fb], 16'h00FF);
      lit("t3_word2", frames[fb + 2], 16'h00FF);
      lit("t3_gap0", gaps[gb], 3);
      lit("t3_gap1", gaps[gb + 1], 3);

      // 4: reset mid-frame
      do_reset();
      bus.data0 = 16'hC3A5; bus.req0 = 1'b1;
      k = 0;
      while (!(in_frame && mon_falls >= 8) && k < 100) begin tick(); k++; end
      lit("t4_reach_8_falls", mon_falls, 8);
      rst_n = 1'b0;
      #1;
      lit("t4_rst_sync", {31'd0, bus.sync_out}, 1);
      lit("t4_rst_clk_out", {31'd0, bus.clk_out}, 1);
      lit("t4_rst_din", {31'd0, bus.din}, 0);
      lit("t4_rst_busy", {31'd0, bus.busy}, 0);
      repeat (2) tick();
      ab = ack_who.size(); fb = frames.size();
      rst_n = 1'b1;
      wait_acks(ab + 1, 10, "t4_ack_timeout");
      bus.req0 = 1'b0;
      wait_frames(fb + 1, 200, "t4_frame_timeout");
      lit("t4_word", frames[fb], 16'hC3A5);
      lit("t4_falls", falls_q[fb], 16);
      lit("t4_sync_low", lens[fb], 64);

      // 5: late request and data change after ack
      do_reset();
      ab = ack_who.size(); fb = frames.size();
      bus.data0 = 16'h5A3C; bus.req0 = 1'b1;
      wait_acks(ab + 1, 10, "t5_ack0_timeout");
      bus.req0 = 1'b0; bus.data0 = 16'hFFFF;
      repeat (20) tick();
      bus.data1 = 16'h0F0F; bus.req1 = 1'b1;
      wait_acks(ab + 2, 100, "t5_ack1_timeout");
      bus.req1 = 1'b0;
      wait_frames(fb + 2, 200, "t5_frame_timeout");
      lit("t5_word0", frames[fb], 16'h5A3C);
      lit("t5_who1", ack_who[ab + 1], 1);
      lit("t5_ack1_delay", ack_cyc[ab + 1] - ack_cyc[ab], T + GP + 1);
      lit("t5_word1", frames[fb + 1], 16'h0F0F);

      // 6: third frame since reset, then idle
      ab = ack_who.size(); fb = frames.size();
      bus.data0 = 16'h0001; bus.req0 = 1'b1;
      wait_acks(ab + 1, 10, "t6_ack_timeout");
      bus.req0 = 1'b0;
      wait_frames(fb + 1, 200, "t6_frame_timeout");
      lit("t6_word", frames[fb], 16'h0001);
      repeat (150) tick();
      lit("t6_led", {31'd0, bus.led}, 1);
      lit("t6_busy", {31'd0, bus.busy}, 0);
      lit("t6_sync", {31'd0, bus.sync_out}, 1);
      lit("t6_clk_out", {31'd0, bus.clk_out}, 1);
      lit("t6_din", {31'd0, bus.din}, 0);
      lit("t6_no_extra_ack", ack_who.size() - ab, 1);

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
